// File: rtl/pf_pkg.sv
// Shared types and constants for the next-line prefetch scheduler and the cache datapath.
package pf_pkg;

  localparam int PF_ADDR_W   = 32;
  localparam int PF_LINE_W   = 256;
  localparam int PF_OFFSET_W = 5;
  localparam int PF_PAGE_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEM   = 2'd1,
    PF_RD = 2'd2
  } pf_state_t;

  // Line-aligned address: clears the byte offset within a cacheline.
  function automatic logic [PF_ADDR_W-1:0] line_addr(input logic [PF_ADDR_W-1:0] addr);
    return {addr[PF_ADDR_W-1:PF_OFFSET_W], {PF_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pf_line_buffer.sv
// Single-entry prefetched line buffer: loaded by a finished prefetch read,
// emptied by the cache consuming it or by demand traffic to the same line.
module pf_line_buffer
  import pf_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int LINE_W = PF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [LINE_W-1:0] i_load_line,
  input  logic              i_dem_req,
  input  logic [ADDR_W-1:0] i_dem_line,
  input  logic              i_ack,
  output logic              o_buf_v,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic [LINE_W-1:0] o_buf_line
);

  logic              r_buf_v;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [LINE_W-1:0] r_buf_line;
  logic              w_stale;

  assign w_stale = r_buf_v & i_dem_req & (i_dem_line == r_buf_addr);

  // A load only happens while the buffer is empty, so it never races a live ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_v    <= 1'b0;
      r_buf_addr <= '0;
      r_buf_line <= '0;
    end else if (i_load) begin
      r_buf_v    <= 1'b1;
      r_buf_addr <= i_load_addr;
      r_buf_line <= i_load_line;
    end else if (i_ack | w_stale) begin
      r_buf_v <= 1'b0;
    end
  end

  assign o_buf_v    = r_buf_v;
  assign o_buf_addr = r_buf_addr;
  assign o_buf_line = r_buf_line;

endmodule

// File: rtl/next_line_prefetch_ctrl.sv
// Next-line prefetch scheduler: shares the single pmem port between demand
// traffic and one-line-ahead prefetch reads, holding one prefetched line.
module next_line_prefetch_ctrl
  import pf_pkg::*;
#(
  parameter int ADDR_W   = PF_ADDR_W,
  parameter int LINE_W   = PF_LINE_W,
  parameter int OFFSET_W = PF_OFFSET_W,
  parameter int PAGE_W   = PF_PAGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_start,
  input  logic [ADDR_W-1:0] dem_addr,
  input  logic              dem_read,
  input  logic              dem_write,
  input  logic [LINE_W-1:0] dem_wdata,
  output logic [LINE_W-1:0] dem_rdata,
  output logic              dem_resp,
  output logic              pf_ready,
  output logic [ADDR_W-1:0] pf_addr,
  output logic [LINE_W-1:0] pf_line,
  input  logic              pf_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  pf_state_t r_state, w_state_next;

  logic                       r_pf_start_d;
  logic                       r_pend_v;
  logic [ADDR_W-1:0]          r_pend_addr;
  logic [ADDR_W-1:0]          r_pf_req_addr;
  logic                       w_buf_v;
  logic [ADDR_W-1:0]          w_buf_addr;
  logic                       w_dem_req;
  logic [ADDR_W-1:0]          w_dem_line;
  logic [ADDR_W-OFFSET_W-1:0] w_nxt_idx;
  logic [ADDR_W-1:0]          w_nxt;
  logic                       w_trig;
  logic                       w_trig_ok;
  logic                       w_pend_hit;
  logic                       w_issue;
  logic                       w_pf_done;

  assign w_dem_req  = dem_read | dem_write;
  assign w_dem_line = line_addr(dem_addr);
  assign w_nxt_idx  = dem_addr[ADDR_W-1:OFFSET_W] + 1'b1;
  assign w_nxt      = {w_nxt_idx, {OFFSET_W{1'b0}}};
  assign w_trig     = pf_start & ~r_pf_start_d;

  // Page check also rejects the top-of-memory wrap to line 0.
  assign w_trig_ok  = w_trig & ~r_pend_v
                    & (w_nxt[ADDR_W-1:PAGE_W] == dem_addr[ADDR_W-1:PAGE_W])
                    & ~(w_buf_v & (w_buf_addr == w_nxt));
  assign w_pend_hit = r_pend_v & w_dem_req & (w_dem_line == r_pend_addr);
  assign w_issue    = (r_state == IDLE) & ~w_dem_req & r_pend_v & ~w_buf_v;
  assign w_pf_done  = (r_state == PF_RD) & mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pf_start_d  <= 1'b0;
      r_pend_v      <= 1'b0;
      r_pend_addr   <= '0;
      r_pf_req_addr <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pf_start_d <= pf_start;
      if (w_trig_ok) begin
        r_pend_v    <= 1'b1;
        r_pend_addr <= w_nxt;
      end else if (w_issue | w_pend_hit) begin
        r_pend_v <= 1'b0;
      end
      if (w_issue) begin
        r_pf_req_addr <= r_pend_addr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_addr     = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;
    dem_resp     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dem_req) begin
          w_state_next = DEM;
        end else if (r_pend_v & ~w_buf_v) begin
          w_state_next = PF_RD;
        end
      end
      DEM: begin
        mem_addr  = dem_addr;
        mem_read  = dem_read;
        mem_write = dem_write;
        mem_wdata = dem_wdata;
        dem_resp  = mem_resp;
        if (mem_resp) w_state_next = IDLE;
      end
      // Prefetch is never preempted; a demand arriving now waits for IDLE.
      PF_RD: begin
        mem_addr = r_pf_req_addr;
        mem_read = 1'b1;
        if (mem_resp) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dem_rdata = mem_rdata;
  assign pf_ready  = w_buf_v;
  assign pf_addr   = w_buf_addr;

  pf_line_buffer #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pf_done),
    .i_load_addr(r_pf_req_addr),
    .i_load_line(mem_rdata),
    .i_dem_req  (w_dem_req),
    .i_dem_line (w_dem_line),
    .i_ack      (pf_ack),
    .o_buf_v    (w_buf_v),
    .o_buf_addr (w_buf_addr),
    .o_buf_line (pf_line)
  );

endmodule

// File: tb/tb_next_line_prefetch_ctrl.sv
// Directed self-checking bench for next_line_prefetch_ctrl with a fixed-latency
// memory responder that returns {8{address}} as line data.
module tb_next_line_prefetch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pf_start = 1'b0;
  logic [31:0]  dem_addr = '0;
  logic         dem_read = 1'b0;
  logic         dem_write = 1'b0;
  logic [255:0] dem_wdata = '0;
  logic [255:0] dem_rdata;
  logic         dem_resp;
  logic         pf_ready;
  logic [31:0]  pf_addr;
  logic [255:0] pf_line;
  logic         pf_ack = 1'b0;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int n_rd = 0;
  int n_wr = 0;
  int rd_at_wr = 0;
  int n_dem_resp = 0;
  int lat_cnt = 0;
  logic [31:0]  last_rd = '0;
  logic [255:0] last_wdata = '0;

  always #5 clk = ~clk;

  next_line_prefetch_ctrl dut (
    .clk(clk), .rst(rst), .pf_start(pf_start),
    .dem_addr(dem_addr), .dem_read(dem_read), .dem_write(dem_write),
    .dem_wdata(dem_wdata), .dem_rdata(dem_rdata), .dem_resp(dem_resp),
    .pf_ready(pf_ready), .pf_addr(pf_addr), .pf_line(pf_line), .pf_ack(pf_ack),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Adapter model: answers each request after 3 observed cycles with a 1-cycle resp.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      lat_cnt  = 0;
      mem_resp = 1'b0;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
    end else if (mem_read | mem_write) begin
      lat_cnt++;
      if (lat_cnt == 3) begin
        lat_cnt   = 0;
        mem_resp  = 1'b1;
        mem_rdata = {8{mem_addr}};
        if (mem_read) begin
          n_rd++;
          last_rd = mem_addr;
        end
        if (mem_write) begin
          n_wr++;
          last_wdata = mem_wdata;
          rd_at_wr   = n_rd;
        end
        $display("mem %s addr=%h", mem_write ? "write" : "read ", mem_addr);
      end
    end
  end

  always @(posedge clk) if (!rst && dem_resp) n_dem_resp++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("check %s ok: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dem_resp(input string tag);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (dem_resp) break;
    end
    chk(tag, 256'(dem_resp), 256'd1);
  endtask

  task automatic wait_pf_ready(input string tag);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (pf_ready) break;
    end
    chk(tag, 256'(pf_ready), 256'd1);
  endtask

  task automatic wait_pf_rd(input string tag, input logic [31:0] a);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (mem_read && mem_addr == a) break;
    end
    chk(tag, 256'(mem_addr), 256'(a));
  endtask

  task automatic do_miss(input string tag, input logic [31:0] a);
    @(negedge clk);
    dem_addr = a;
    dem_read = 1'b1;
    pf_start = 1'b1;
    wait_dem_resp(tag);
    dem_read = 1'b0;
    pf_start = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    pf_ack = 1'b1;
    @(negedge clk);
    pf_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_rd;
    int base_resp;

    // Reset state
    idle(3);
    chk("rst_pf_ready", 256'(pf_ready), 256'd0);
    chk("rst_pf_addr", 256'(pf_addr), 256'd0);
    chk("rst_pf_line", pf_line, 256'd0);
    chk("rst_mem_read", 256'(mem_read), 256'd0);
    chk("rst_mem_write", 256'(mem_write), 256'd0);
    chk("rst_mem_addr", 256'(mem_addr), 256'd0);
    chk("rst_dem_resp", 256'(dem_resp), 256'd0);
    rst = 1'b0;
    idle(2);

    // Miss at 0x1040: demand issued the cycle after the request, then prefetch 0x1060
    @(negedge clk);
    dem_addr = 32'h0000_1040;
    dem_read = 1'b1;
    pf_start = 1'b1;
    @(negedge clk);
    chk("t1_lat_mem_read", 256'(mem_read), 256'd1);
    chk("t1_lat_mem_addr", 256'(mem_addr), 256'h1040);
    wait_dem_resp("t1_dem_resp");
    chk("t1_dem_rdata", dem_rdata, {8{32'h0000_1040}});
    dem_read = 1'b0;
    pf_start = 1'b0;
    wait_pf_ready("t1_pf_ready");
    chk("t1_pf_addr", 256'(pf_addr), 256'h1060);
    chk("t1_pf_line", pf_line, {8{32'h0000_1060}});
    chk("t1_rd_count", 256'(n_rd), 256'd2);
    ack_pulse();
    chk("t1_ack_clears", 256'(pf_ready), 256'd0);

    // Page-crossing and wrap-around triggers produce no prefetch
    do_miss("t2_resp_page", 32'h0000_1FE0);
    idle(12);
    chk("t2_page_rd_count", 256'(n_rd), 256'd3);
    chk("t2_page_no_ready", 256'(pf_ready), 256'd0);
    chk("t2_page_idle", 256'(mem_read), 256'd0);
    do_miss("t2_resp_wrap", 32'hFFFF_FFE0);
    idle(12);
    chk("t2_wrap_rd_count", 256'(n_rd), 256'd4);
    chk("t2_wrap_no_ready", 256'(pf_ready), 256'd0);

    // Demand write during an in-flight prefetch waits, then completes once
    do_miss("t3_miss_resp", 32'h0000_3000);
    wait_pf_rd("t3_pf_rd", 32'h0000_3020);
    dem_addr  = 32'h0000_4000;
    dem_wdata = {8{32'hA5A5_0001}};
    dem_write = 1'b1;
    base_resp = n_dem_resp;
    @(negedge clk);
    chk("t3_write_stalled", 256'(mem_write), 256'd0);
    chk("t3_stall_addr", 256'(mem_addr), 256'h3020);
    wait_dem_resp("t3_write_resp");
    dem_write = 1'b0;
    idle(6);
    chk("t3_write_after_pf", 256'(rd_at_wr), 256'd6);
    chk("t3_wdata", last_wdata, {8{32'hA5A5_0001}});
    chk("t3_resp_once", 256'(n_dem_resp - base_resp), 256'd1);
    chk("t3_pf_addr", 256'(pf_addr), 256'h3020);
    chk("t3_pf_ready", 256'(pf_ready), 256'd1);
    ack_pulse();

    // Demand write to the buffered line drops it next cycle without a refill
    do_miss("t4_miss_resp", 32'h0000_2020);
    wait_pf_ready("t4_pf_ready");
    chk("t4_pf_addr", 256'(pf_addr), 256'h2040);
    base_rd = n_rd;
    @(negedge clk);
    dem_addr  = 32'h0000_2040;
    dem_wdata = {8{32'h5A5A_0002}};
    dem_write = 1'b1;
    @(negedge clk);
    chk("t4_inval", 256'(pf_ready), 256'd0);
    wait_dem_resp("t4_write_resp");
    dem_write = 1'b0;
    idle(12);
    chk("t4_no_refill", 256'(n_rd), 256'(base_rd));
    chk("t4_still_empty", 256'(pf_ready), 256'd0);

    // Second trigger while one prefetch is pending is dropped
    base_rd = n_rd;
    do_miss("t5_miss_a", 32'h0000_5000);
    wait_pf_ready("t5_ready_a");
    do_miss("t5_miss_b", 32'h0000_6000);
    do_miss("t5_miss_c", 32'h0000_7000);
    idle(5);
    chk("t5_held", 256'(n_rd), 256'(base_rd + 4));
    ack_pulse();
    wait_pf_ready("t5_ready_b");
    chk("t5_pf_addr", 256'(pf_addr), 256'h6020);
    ack_pulse();
    idle(15);
    chk("t5_one_prefetch", 256'(n_rd), 256'(base_rd + 5));
    chk("t5_last_rd", 256'(last_rd), 256'h6020);
    chk("t5_empty", 256'(pf_ready), 256'd0);

    // Reset during a prefetch read aborts it and clears all state
    do_miss("t6_miss_resp", 32'h0000_8000);
    wait_pf_rd("t6_pf_rd", 32'h0000_8020);
    base_rd = n_rd;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_mem_read", 256'(mem_read), 256'd0);
    chk("t6_rst_pf_ready", 256'(pf_ready), 256'd0);
    chk("t6_rst_mem_addr", 256'(mem_addr), 256'd0);
    rst = 1'b0;
    idle(15);
    chk("t6_no_resume", 256'(n_rd), 256'(base_rd));
    chk("t6_idle", 256'(mem_read), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
